// File: rtl/alsu_scoreboard.sv
// alsu_scoreboard: passive checker for the ALSU. Re-creates the ALSU's two
// register pipeline from the monitored stimulus bus, compares it against the
// real ALSU out/leds each cycle while checking, and keeps saturating counts.
module alsu_scoreboard #(
  parameter string       INPUT_PRIORITY = "A",
  parameter string       FULL_ADDER     = "ON",
  parameter int unsigned STOP_ON_ERR    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear,
  input  logic [2:0]  mon_A,
  input  logic [2:0]  mon_B,
  input  logic [2:0]  mon_opcode,
  input  logic        mon_cin,
  input  logic        mon_serial_in,
  input  logic        mon_direction,
  input  logic        mon_red_op_A,
  input  logic        mon_red_op_B,
  input  logic        mon_bypass_A,
  input  logic        mon_bypass_B,
  input  logic [5:0]  mon_out,
  input  logic [15:0] mon_leds,
  output logic        mismatch,
  output logic [15:0] check_count,
  output logic [15:0] error_count,
  output logic [2:0]  first_err_opcode,
  output logic        halted
);

  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");
  localparam bit STOP    = (STOP_ON_ERR != 0);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_CHECK, S_HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_prime_cnt;

  logic [2:0]  r_A, r_B, r_opcode;
  logic        r_cin, r_serial_in, r_direction;
  logic        r_red_op_A, r_red_op_B, r_bypass_A, r_bypass_B;

  logic [5:0]  r_exp_out, w_exp_out_nxt;
  logic [15:0] r_exp_leds, w_exp_leds_nxt;
  logic [2:0]  r_exp_opcode;

  logic        w_invalid;
  logic [2:0]  w_byp_sel, w_red_sel;

  logic        w_compare, w_fail;
  logic [15:0] w_cc_inc;

  logic        r_mismatch;
  logic [15:0] r_check_count, r_error_count;
  logic [2:0]  r_first_err_opcode;

  // Stage 1: capture the stimulus exactly as the ALSU's input registers do
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_A           <= '0;
      r_B           <= '0;
      r_opcode      <= '0;
      r_cin         <= 1'b0;
      r_serial_in   <= 1'b0;
      r_direction   <= 1'b0;
      r_red_op_A    <= 1'b0;
      r_red_op_B    <= 1'b0;
      r_bypass_A    <= 1'b0;
      r_bypass_B    <= 1'b0;
    end else begin
      r_A           <= mon_A;
      r_B           <= mon_B;
      r_opcode      <= mon_opcode;
      r_cin         <= mon_cin;
      r_serial_in   <= mon_serial_in;
      r_direction   <= mon_direction;
      r_red_op_A    <= mon_red_op_A;
      r_red_op_B    <= mon_red_op_B;
      r_bypass_A    <= mon_bypass_A;
      r_bypass_B    <= mon_bypass_B;
    end
  end

  // Shadow ALSU datapath: next expected out/leds from stage 1 and previous out
  always_comb begin
    w_invalid = (r_opcode == 3'd6) || (r_opcode == 3'd7) ||
                ((r_red_op_A || r_red_op_B) && (r_opcode > 3'd1));
    w_byp_sel = (r_bypass_A && (!r_bypass_B || PRIO_A)) ? r_A : r_B;
    w_red_sel = (r_red_op_A && (!r_red_op_B || PRIO_A)) ? r_A : r_B;
    w_exp_out_nxt = '0;
    if (r_bypass_A || r_bypass_B) begin
      w_exp_out_nxt = {3'b000, w_byp_sel};
    end else if (!w_invalid) begin
      case (r_opcode)
        3'd0: w_exp_out_nxt = (r_red_op_A || r_red_op_B) ? {5'b0, &w_red_sel}
                                                         : {3'b000, r_A & r_B};
        3'd1: w_exp_out_nxt = (r_red_op_A || r_red_op_B) ? {5'b0, ^w_red_sel}
                                                         : {3'b000, r_A ^ r_B};
        3'd2: w_exp_out_nxt = {3'b000, r_A} + {3'b000, r_B} + {5'b0, r_cin & USE_CIN};
        3'd3: w_exp_out_nxt = {3'b000, r_A} * {3'b000, r_B};
        3'd4: w_exp_out_nxt = r_direction ? {r_exp_out[4:0], r_serial_in}
                                          : {r_serial_in, r_exp_out[5:1]};
        3'd5: w_exp_out_nxt = r_direction ? {r_exp_out[4:0], r_exp_out[5]}
                                          : {r_exp_out[0], r_exp_out[5:1]};
        default: w_exp_out_nxt = '0;
      endcase
    end
    w_exp_leds_nxt = w_invalid ? ~r_exp_leds : '0;
  end

  // Stage 2: expected outputs plus the opcode that produced them
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_exp_out    <= '0;
      r_exp_leds   <= '0;
      r_exp_opcode <= '0;
    end else begin
      r_exp_out    <= w_exp_out_nxt;
      r_exp_leds   <= w_exp_leds_nxt;
      r_exp_opcode <= r_opcode;
    end
  end

  assign w_compare = (r_state == S_CHECK);
  assign w_fail    = w_compare && ((mon_out != r_exp_out) || (mon_leds != r_exp_leds));
  assign w_cc_inc  = (r_check_count == 16'hFFFF) ? r_check_count : r_check_count + 16'd1;

  // Checker state register; prime counter marks the second PRIME cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_prime_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prime_cnt <= (r_state == S_PRIME) && (w_state_nxt == S_PRIME);
    end
  end

  // Checker next state; a compare discarded by clear cannot trigger HALT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_PRIME;
      S_PRIME: begin
        if (!enable)          w_state_nxt = S_IDLE;
        else if (r_prime_cnt) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!clear && w_fail && STOP)              w_state_nxt = S_HALT;
        else if (!clear && w_cc_inc == 16'hFFFF)   w_state_nxt = S_HALT;
        else if (!enable)                          w_state_nxt = S_IDLE;
      end
      S_HALT:  if (clear) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Statistics: registered mismatch flag, saturating counters, first error
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mismatch         <= 1'b0;
      r_check_count      <= '0;
      r_error_count      <= '0;
      r_first_err_opcode <= '0;
    end else begin
      r_mismatch <= w_fail;
      if (clear) begin
        r_check_count <= '0;
        r_error_count <= '0;
      end else if (w_compare) begin
        r_check_count <= w_cc_inc;
        if (w_fail) begin
          if (r_error_count != 16'hFFFF) r_error_count <= r_error_count + 16'd1;
          if (r_error_count == '0)       r_first_err_opcode <= r_exp_opcode;
        end
      end
    end
  end

  assign mismatch         = r_mismatch;
  assign check_count      = r_check_count;
  assign error_count      = r_error_count;
  assign first_err_opcode = r_first_err_opcode;
  assign halted           = (r_state == S_HALT);

endmodule

// File: tb/tb_alsu_scoreboard.sv
// Bench for alsu_scoreboard: acts as the ALSU itself (driving mon_out/mon_leds
// from a reference model, with optional deliberate corruption) and checks two
// scoreboards, one free-running and one that stops on the first error.
module tb_alsu_scoreboard;

  localparam bit PRIO_A = 1'b1;   // INPUT_PRIORITY "A"
  localparam bit FA     = 1'b1;   // FULL_ADDER "ON"

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] op;
    logic cin, ser, dir, ra, rb, ba, bb;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, clear;
  logic [2:0]  mon_A, mon_B, mon_opcode;
  logic        mon_cin, mon_serial_in, mon_direction;
  logic        mon_red_op_A, mon_red_op_B, mon_bypass_A, mon_bypass_B;
  logic [5:0]  mon_out;
  logic [15:0] mon_leds;

  logic        d_mm   [2];
  logic [15:0] d_cc   [2];
  logic [15:0] d_ec   [2];
  logic [2:0]  d_fe   [2];
  logic        d_halt [2];

  alsu_scoreboard dut0 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .mon_A(mon_A), .mon_B(mon_B), .mon_opcode(mon_opcode),
    .mon_cin(mon_cin), .mon_serial_in(mon_serial_in), .mon_direction(mon_direction),
    .mon_red_op_A(mon_red_op_A), .mon_red_op_B(mon_red_op_B),
    .mon_bypass_A(mon_bypass_A), .mon_bypass_B(mon_bypass_B),
    .mon_out(mon_out), .mon_leds(mon_leds),
    .mismatch(d_mm[0]), .check_count(d_cc[0]), .error_count(d_ec[0]),
    .first_err_opcode(d_fe[0]), .halted(d_halt[0])
  );

  alsu_scoreboard #(.STOP_ON_ERR(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .mon_A(mon_A), .mon_B(mon_B), .mon_opcode(mon_opcode),
    .mon_cin(mon_cin), .mon_serial_in(mon_serial_in), .mon_direction(mon_direction),
    .mon_red_op_A(mon_red_op_A), .mon_red_op_B(mon_red_op_B),
    .mon_bypass_A(mon_bypass_A), .mon_bypass_B(mon_bypass_B),
    .mon_out(mon_out), .mon_leds(mon_leds),
    .mismatch(d_mm[1]), .check_count(d_cc[1]), .error_count(d_ec[1]),
    .first_err_opcode(d_fe[1]), .halted(d_halt[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit run     = 1'b0;

  // Reference ALSU: the value the real ALSU shows after each edge
  int    m_out = 0, m_leds = 0, m_s2op = 0;
  stim_t m_s1 = '0;
  // Expected checker behaviour per instance (0 idle, 1 prime, 2 check, 3 halt)
  int m_st[2], m_pc[2], m_cc[2], m_ec[2], m_fe[2], m_mm[2];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int parity3(input int x);
    return (x % 2 + (x / 2) % 2 + x / 4) % 2;
  endfunction

  function automatic void alsu_next(input stim_t s, input int po, input int pl,
                                    output int o, output int l);
    int  a, b, x, op;
    bit  red, inv;
    a   = int'(s.a);
    b   = int'(s.b);
    op  = int'(s.op);
    red = s.ra || s.rb;
    inv = (op >= 6) || (red && op >= 2);
    x   = (s.ra && (!s.rb || PRIO_A)) ? a : b;
    l   = inv ? (pl ^ 'hFFFF) : 0;
    o   = 0;
    if (s.ba || s.bb) o = (s.ba && (!s.bb || PRIO_A)) ? a : b;
    else if (!inv) begin
      case (op)
        0: o = red ? ((x == 7) ? 1 : 0) : (a & b);
        1: o = red ? parity3(x) : (a ^ b);
        2: o = a + b + ((FA && s.cin) ? 1 : 0);
        3: o = a * b;
        4: o = s.dir ? ((po * 2) % 64 + int'(s.ser)) : (int'(s.ser) * 32 + po / 2);
        5: o = s.dir ? ((po * 2) % 64 + po / 32) : ((po % 2) * 32 + po / 2);
        default: o = 0;
      endcase
    end
  endfunction

  task automatic fsm_step(input int i, input bit r, input bit en, input bit clr, input bit bad);
    bit fail;
    if (!r) begin
      m_st[i] = 0; m_pc[i] = 0; m_cc[i] = 0; m_ec[i] = 0; m_fe[i] = 0; m_mm[i] = 0;
      return;
    end
    fail    = (m_st[i] == 2) && bad;
    m_mm[i] = fail ? 1 : 0;
    if (clr) begin m_cc[i] = 0; m_ec[i] = 0; end
    case (m_st[i])
      0: if (en) begin m_st[i] = 1; m_pc[i] = 0; end
      1: if (!en) m_st[i] = 0;
         else if (m_pc[i] == 1) m_st[i] = 2;
         else m_pc[i] = 1;
      2: if (clr) begin
           if (!en) m_st[i] = 0;
         end else begin
           if (m_cc[i] < 65535) m_cc[i]++;
           if (fail) begin
             if (m_ec[i] == 0) m_fe[i] = m_s2op;
             if (m_ec[i] < 65535) m_ec[i]++;
           end
           if (fail && i == 1) m_st[i] = 3;
           else if (m_cc[i] == 65535) m_st[i] = 3;
           else if (!en) m_st[i] = 0;
         end
      default: if (clr) m_st[i] = 0;
    endcase
  endtask

  task automatic alsu_step(input stim_t s, input bit r);
    int o, l;
    if (!r) begin
      m_out = 0; m_leds = 0; m_s2op = 0; m_s1 = '0;
    end else begin
      alsu_next(m_s1, m_out, m_leds, o, l);
      m_out  = o;
      m_leds = l;
      m_s2op = int'(m_s1.op);
      m_s1   = s;
    end
  endtask

  // One clock: drive stimulus and (possibly corrupted) ALSU result, advance models
  task automatic cyc(input stim_t s, input bit r, input bit en, input bit clr,
                     input int xo, input int xl);
    bit bad;
    mon_A = s.a; mon_B = s.b; mon_opcode = s.op;
    mon_cin = s.cin; mon_serial_in = s.ser; mon_direction = s.dir;
    mon_red_op_A = s.ra; mon_red_op_B = s.rb;
    mon_bypass_A = s.ba; mon_bypass_B = s.bb;
    rst = r; enable = en; clear = clr;
    mon_out  = 6'(m_out ^ xo);
    mon_leds = 16'(m_leds ^ xl);
    bad = ((xo % 64) != 0) || ((xl % 65536) != 0);
    @(posedge clk);
    for (int i = 0; i < 2; i++) fsm_step(i, r, en, clr, bad);
    alsu_step(s, r);
    #1;
  endtask

  function automatic stim_t mk(input int a, input int b, input int op,
                               input bit cin = 0, input bit ser = 0, input bit dir = 0,
                               input bit ra = 0, input bit rb = 0,
                               input bit ba = 0, input bit bb = 0);
    stim_t s;
    s.a = 3'(a); s.b = 3'(b); s.op = 3'(op);
    s.cin = cin; s.ser = ser; s.dir = dir;
    s.ra = ra; s.rb = rb; s.ba = ba; s.bb = bb;
    return s;
  endfunction

  // Every cycle: both scoreboards against the expected checker behaviour
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("mismatch[%0d]", i), int'(d_mm[i]), m_mm[i]);
        chk($sformatf("check_count[%0d]", i), int'(d_cc[i]), m_cc[i]);
        chk($sformatf("error_count[%0d]", i), int'(d_ec[i]), m_ec[i]);
        chk($sformatf("first_err_opcode[%0d]", i), int'(d_fe[i]), m_fe[i]);
        chk($sformatf("halted[%0d]", i), int'(d_halt[i]), (m_st[i] == 3) ? 1 : 0);
      end
    end
  end

  initial begin
    stim_t z;
    z = '0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_pc[i] = 0; m_cc[i] = 0; m_ec[i] = 0; m_fe[i] = 0; m_mm[i] = 0;
    end

    // Reset
    cyc(z, 0, 0, 0, 0, 0);
    run = 1'b1;
    cyc(z, 0, 1, 1, 0, 0);
    chk("reset_cc", int'(d_cc[0]), 0);
    chk("reset_halted", int'(d_halt[1]), 0);

    // Pipeline alignment: 3+5+1
    repeat (5) cyc(mk(3, 5, 2, 1), 1, 1, 0, 0, 0);
    chk("add_model", m_out, 9);
    chk("add_cc", int'(d_cc[0]), 2);
    chk("add_ec", int'(d_ec[0]), 0);

    // Invalid opcode blink, leds corrupted on one compare
    cyc(mk(3, 5, 6), 1, 1, 0, 0, 0);
    cyc(mk(3, 5, 6), 1, 1, 0, 0, 0);
    chk("blink_out", m_out, 0);
    chk("blink_leds1", m_leds, 'hFFFF);
    cyc(mk(3, 5, 6), 1, 1, 0, 0, 'hFFFF);
    chk("blink_leds2", m_leds, 0);
    chk("blink_mm", int'(d_mm[0]), 1);
    chk("blink_ec", int'(d_ec[0]), 1);
    chk("blink_cc", int'(d_cc[0]), 5);
    chk("blink_fe", int'(d_fe[0]), 6);
    chk("stop_halt_a", int'(d_halt[1]), 1);
    cyc(mk(3, 5, 6), 1, 1, 0, 0, 0);
    chk("blink_leds3", m_leds, 'hFFFF);
    cyc(mk(3, 5, 6), 1, 1, 0, 0, 0);
    chk("blink_leds4", m_leds, 0);
    chk("halt_frozen_cc", int'(d_cc[1]), 5);

    // Clear with a failing compare in the same cycle
    cyc(z, 1, 1, 1, 1, 0);
    chk("clr_mm", int'(d_mm[0]), 1);
    chk("clr_ec", int'(d_ec[0]), 0);
    chk("clr_cc", int'(d_cc[0]), 0);
    chk("clr_unhalt", int'(d_halt[1]), 0);

    // Shift / rotate history
    cyc(mk(2, 3, 2), 1, 1, 0, 0, 0);
    cyc(mk(0, 0, 4, 0, 1, 1), 1, 1, 0, 0, 0);
    chk("hist_base", m_out, 5);
    cyc(mk(0, 0, 5, 0, 0, 0), 1, 1, 0, 0, 0);
    chk("hist_shift", m_out, 11);
    cyc(z, 1, 1, 0, 0, 0);
    chk("hist_rot", m_out, 37);
    cyc(z, 1, 1, 0, 0, 0);

    // Reduction and bypass priority
    cyc(mk(7, 3, 0, 0, 0, 0, 1, 1), 1, 1, 0, 0, 0);
    cyc(mk(7, 3, 0, 0, 0, 0, 1, 1, 1, 1), 1, 1, 0, 0, 0);
    chk("red_and_prio", m_out, 1);
    cyc(mk(7, 6, 1, 0, 0, 0, 0, 1), 1, 1, 0, 0, 0);
    chk("byp_prio", m_out, 7);
    cyc(mk(7, 3, 1, 0, 0, 0, 1, 0), 1, 1, 0, 0, 0);
    chk("red_xor_b", m_out, 0);
    cyc(mk(7, 3, 7, 0, 0, 0, 0, 0, 0, 1), 1, 1, 0, 0, 0);
    chk("red_xor_a", m_out, 1);
    cyc(mk(7, 7, 3), 1, 1, 0, 0, 0);
    chk("byp_b_invalid", m_out, 3);
    chk("byp_blink", m_leds, 'hFFFF);

    // Stop on error: 7*7 reported as 0
    cyc(mk(7, 7, 3), 1, 1, 0, 0, 0);
    chk("mul_model", m_out, 49);
    cyc(mk(7, 7, 3), 1, 1, 0, 49, 0);
    chk("stop_halt", int'(d_halt[1]), 1);
    chk("stop_fe", int'(d_fe[1]), 3);
    chk("stop_cc", int'(d_cc[1]), 10);
    chk("free_fe", int'(d_fe[0]), 3);
    chk("free_cc", int'(d_cc[0]), 13);
    cyc(mk(7, 7, 3), 1, 1, 0, 0, 0);
    cyc(mk(7, 7, 3), 1, 1, 0, 0, 0);
    chk("stop_frozen", int'(d_cc[1]), 10);
    cyc(mk(7, 7, 3), 1, 1, 1, 0, 0);
    chk("stop_clr_halt", int'(d_halt[1]), 0);
    chk("stop_clr_cc", int'(d_cc[1]), 0);
    chk("stop_clr_ec", int'(d_ec[1]), 0);

    // Five errors, then reset mid-run
    repeat (5) cyc(mk(7, 7, 3), 1, 1, 0, 1, 0);
    chk("five_err", int'(d_ec[0]), 5);
    cyc(mk(1, 1, 2), 0, 1, 0, 0, 0);
    chk("rst_ec", int'(d_ec[0]), 0);
    chk("rst_cc", int'(d_cc[0]), 0);
    chk("rst_fe", int'(d_fe[0]), 0);
    chk("rst_model", m_out, 0);
    repeat (3) cyc(mk(1, 1, 2), 1, 1, 0, 0, 0);
    chk("reprime_cc", int'(d_cc[0]), 0);
    cyc(mk(1, 1, 2), 1, 1, 0, 0, 0);
    chk("recheck_cc", int'(d_cc[0]), 1);
    chk("recheck_model", m_out, 2);

    // Failure together with enable dropping
    cyc(mk(1, 1, 2), 1, 0, 0, 1, 0);
    chk("dis_fail_ec", int'(d_ec[0]), 1);
    chk("dis_fail_cc", int'(d_cc[0]), 2);
    cyc(mk(1, 1, 2), 1, 0, 0, 1, 0);
    chk("dis_idle_cc", int'(d_cc[0]), 2);

    // Enable dropped during PRIME
    cyc(z, 1, 1, 0, 0, 0);
    cyc(z, 1, 0, 0, 0, 0);
    cyc(z, 1, 1, 0, 0, 0);
    cyc(z, 1, 1, 0, 0, 0);
    chk("prime_abort_cc", int'(d_cc[0]), 2);
    cyc(z, 1, 1, 0, 0, 0);
    cyc(z, 1, 1, 0, 0, 0);
    chk("prime_restart_cc", int'(d_cc[0]), 3);

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alsu_scoreboard.md
Name: alsu_scoreboard

Overview:
- Synthesizable self-checking monitor at the far end of the ALSU stimulus interface.
- Taps the same A/B/opcode/control bus the stimulus driver applies to the ALSU, plus the ALSU out/leds.
- Holds a cycle-accurate shadow model of the ALSU's 2-register pipeline, compares each cycle and accumulates pass/error statistics.
- Sits beside the ALSU in the bench or on-board, with results routed to a debug port.

Parameters:
- INPUT_PRIORITY, "A": operand that wins when both red_op or both bypass bits are set ("A" or "B").
- FULL_ADDER, "ON": "ON" adds cin in opcode 2; "OFF" ignores cin.
- STOP_ON_ERR, 0: 1 means halt checking on the first mismatch.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  checking enable; the shadow model tracks regardless.
- clear  in  1  one-cycle pulse; zeroes counters, leaves HALT.
- mon_A, mon_B  in  3 each  operands as driven to the ALSU.
- mon_opcode  in  3  opcode as driven.
- mon_cin, mon_serial_in, mon_direction  in  1 each  as driven.
- mon_red_op_A, mon_red_op_B, mon_bypass_A, mon_bypass_B  in  1 each  as driven.
- mon_out  in  6  ALSU out.
- mon_leds  in  16  ALSU leds.
- mismatch  out  1  registered; 1 for one cycle per failing compare.
- check_count  out  16  compares performed, saturating.
- error_count  out  16  mismatches, saturating.
- first_err_opcode  out  3  registered opcode of the first mismatch since reset/clear.
- halted  out  1  1 while in HALT.

Behaviour:
- Reset (rst=0 at an edge):
  - All outputs and shadow registers go to 0; FSM goes to IDLE.
  - Reset has priority over clear and enable.
- Stage 1: on every edge, register all mon_* inputs except mon_out/mon_leds into r_*.
- Stage 2: exp_out/exp_leds update every edge from r_* and the previous exp_out. Priority, highest first:
  1. Bypass. bypass_A&bypass_B selects the INPUT_PRIORITY operand; bypass_A alone gives A; bypass_B alone gives B.
  2. Invalid gives exp_out=0. Invalid is opcode 6/7, or (red_op_A|red_op_B) with opcode not 0/1.
  3. op0: red_A gives &A, red_B gives &B (both set: INPUT_PRIORITY operand), otherwise A&B.
  4. op1: same selection as op0 with XOR.
  5. op2: A+B(+cin per FULL_ADDER).
  6. op3: A*B.
  7. op4 shift: direction=1 gives {out[4:0],serial_in}; direction=0 gives {serial_in,out[5:1]}.
  8. op5 rotate: direction=1 gives {out[4:0],out[5]}; direction=0 gives {out[0],out[5:1]}.
- Width rule: results are zero-extended to 6 bits. Max value is 49 (7*7), so no truncation occurs.
- exp_leds: when invalid, exp_leds = ~exp_leds (blink); otherwise 0. Bypass does not suppress the blink.
- Compare: combinational (mon_out!=exp_out)|(mon_leds!=exp_leds), evaluated only in CHECK. Result is registered into mismatch, giving 1-cycle latency.
- FSM:
  - IDLE: enable=1 goes to PRIME.
  - PRIME: stays exactly 2 cycles, flushing stimulus applied while disabled, then goes to CHECK. Dropping enable returns to IDLE.
  - CHECK: each cycle check_count+1 and, on failure, error_count+1. enable=0 goes to IDLE. A failure with STOP_ON_ERR=1 goes to HALT. check_count reaching 16'hFFFF goes to HALT.
  - HALT: halted=1, counters frozen, no compares. Leaves only on rst or clear, going to IDLE.
- Counters saturate at 16'hFFFF and never wrap.
- first_err_opcode latches r_opcode aligned to the failing compare, only when error_count was 0.
- clear in CHECK: counters zero that cycle; a compare in that same cycle is discarded. mismatch still reports it.
- Simultaneous enable=0 and failure: the failure is counted, then the FSM goes to IDLE.
- The shadow model is never gated. Shift/rotate history stays aligned across enable toggles.

Test Plan:
- Pipeline alignment: rst=0 then 1, enable=1, drive A=3,B=5,op=2,cin=1, FULL_ADDER="ON" -> after PRIME, mon_out=9 gives mismatch=0, check_count increments, error_count=0.
- Invalid blink: op=6, no bypass, held 4 cycles -> exp_out=0, exp_leds toggles 0->FFFF->0->FFFF. Forcing mon_leds=0 on the 2nd compare gives mismatch=1 and error_count=1.
- Shift/rotate history: exp_out=6'b000101, op=4, direction=1, serial_in=1 -> 001011; then op=5, direction=0 -> 100101.
- Reduction/bypass priority: red_op_A=red_op_B=1, op=0, A=7, B=3, INPUT_PRIORITY="A" -> expect 1. Then bypass_A=bypass_B=1 -> expect out=7.
- Stop/clear: STOP_ON_ERR=1, inject a wrong mon_out=0 on op=3, A=7, B=7 (expect 49) -> halted=1, first_err_opcode=3, counters frozen. A clear pulse zeroes counters and returns to IDLE.
- Reset mid-run: rst=0 for one cycle during CHECK with error_count=5 -> all outputs 0, exp_out=0, FSM in IDLE, then PRIME repeats for 2 cycles.
